// File: rtl/read_32bit_from_ip_ram_if.sv
// read_32bit_from_ip_ram_if: request, RAM port-A and result signals of the 32-bit RAM reader
interface read_32bit_from_ip_ram_if #(parameter int ADDR_W = 19);
  logic              start;
  logic [ADDR_W-1:0] address;
  logic [7:0]        ram_q;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_rd_active;
  logic [31:0]       data_out;
  logic              done;
  logic              busy;
  logic              align_err;
  modport slave (input start, address, ram_q,
                 output ram_address, ram_rd_active, data_out, done, busy, align_err);
  modport master (output start, address, ram_q,
                  input ram_address, ram_rd_active, data_out, done, busy, align_err);
endinterface

// File: rtl/read_32bit_from_ip_ram.sv
// read_32bit_from_ip_ram: fetches a little-endian 32-bit word from byte-wide RAM port A
// Optional misaligned-address rejection is enabled by defining READ32_ALIGN_CHECK_EN.
module read_32bit_from_ip_ram #(
  parameter int ADDR_W       = 19,
  parameter int READ_LATENCY = 1
) (
  input logic                      clk,
  input logic                      rst,
  read_32bit_from_ip_ram_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  localparam logic [2:0] LAT = 3'(READ_LATENCY);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, ram_address_q, ram_address_d;
  logic [2:0]        cyc_q, cyc_d;
  logic [23:0]       buf_q, buf_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              align_err_q, align_err_d;
  logic              misaligned, active, capture;
`ifdef READ32_ALIGN_CHECK_EN
  assign misaligned = bus.address[1:0] != 2'b00;
`else
  assign misaligned = 1'b0;
`endif
  assign active  = state_q == ISSUE || state_q == DRAIN;
  // cyc_q counts edges since the accepting edge minus one, so byte i arrives when cyc_q == i+LAT
  assign capture = active && cyc_q >= LAT;
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    ram_address_d = ram_address_q;
    cyc_d         = cyc_q;
    buf_d         = buf_q;
    data_out_d    = data_out_q;
    align_err_d   = 1'b0;
    if (state_q == IDLE && bus.start) begin
      state_d       = misaligned ? DONE : ISSUE;
      align_err_d   = misaligned;
      base_d        = misaligned ? base_q : bus.address;
      ram_address_d = misaligned ? ram_address_q : bus.address;
      cyc_d         = 3'd0;
    end
    if (active) begin
      cyc_d = cyc_q + 3'd1;
      buf_d = capture ? {bus.ram_q, buf_q[23:8]} : buf_q;
    end
    if (state_q == ISSUE) begin
      ram_address_d = base_q + ADDR_W'(cyc_q + 3'd1);
      state_d       = cyc_q == 3'd2 ? DRAIN : ISSUE;
    end
    if (state_q == DRAIN && cyc_q == LAT + 3'd3) begin
      data_out_d = {bus.ram_q, buf_q};
      state_d    = DONE;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      ram_address_q <= '0;
      cyc_q         <= '0;
      buf_q         <= '0;
      data_out_q    <= '0;
      align_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      ram_address_q <= ram_address_d;
      cyc_q         <= cyc_d;
      buf_q         <= buf_d;
      data_out_q    <= data_out_d;
      align_err_q   <= align_err_d;
    end
  end
  assign bus.ram_address   = ram_address_q;
  assign bus.data_out      = data_out_q;
  assign bus.done          = state_q == DONE;
  assign bus.busy          = active;
  assign bus.ram_rd_active = active;
  assign bus.align_err     = align_err_q;
endmodule

// File: tb/tb_read_32bit_from_ip_ram.sv
// tb_read_32bit_from_ip_ram: directed checks of the 32-bit RAM reader at latency 1 and 2
module tb_read_32bit_from_ip_ram;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   n_done, n_bad;
  logic [31:0] seen_data;
  bit   [7:0] mem [0:(1<<19)-1];
  logic [7:0] q2_stage;
  read_32bit_from_ip_ram_if #(.ADDR_W(19)) b1();
  read_32bit_from_ip_ram_if #(.ADDR_W(19)) b2();
  read_32bit_from_ip_ram #(.ADDR_W(19), .READ_LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(b1.slave));
  read_32bit_from_ip_ram #(.ADDR_W(19), .READ_LATENCY(2)) dut2 (.clk(clk), .rst(rst), .bus(b2.slave));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    b1.ram_q <= mem[b1.ram_address];
    q2_stage <= mem[b2.ram_address];
    b2.ram_q <= q2_stage;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic track();
    if (b1.ram_address == 19'h00100) n_bad++;
    if (b1.done) begin
      n_done++;
      seen_data = b1.data_out;
    end
  endtask
  initial begin
    mem[19'h30E50] = 8'h78; mem[19'h30E51] = 8'h56;
    mem[19'h30E52] = 8'h34; mem[19'h30E53] = 8'h12;
    mem[19'h30E54] = 8'h9A;
    mem[19'h7FFFE] = 8'hAA; mem[19'h7FFFF] = 8'hBB;
    mem[19'h00000] = 8'hCC; mem[19'h00001] = 8'hDD;
    mem[19'h00100] = 8'h11; mem[19'h00101] = 8'h22;
    mem[19'h00102] = 8'h33; mem[19'h00103] = 8'h44;
    rst = 1'b0;
    b1.start = 1'b0; b1.address = '0;
    b2.start = 1'b0; b2.address = '0;
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(b1.ram_address), 32'h0);
    chk("rst_data", b1.data_out, 32'h0);
    chk("rst_done", 32'(b1.done), 32'h0);
    chk("rst_busy", 32'(b1.busy), 32'h0);
    chk("rst_active", 32'(b1.ram_rd_active), 32'h0);
    chk("rst_align", 32'(b1.align_err), 32'h0);
    rst = 1'b1;
    // latency 1 basic read
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h30E50;
    @(negedge clk); b1.start = 1'b0;
    chk("l1_addr0", 32'(b1.ram_address), 32'h30E50);
    chk("l1_busy", 32'(b1.busy), 32'h1);
    chk("l1_active", 32'(b1.ram_rd_active), 32'h1);
    @(negedge clk); chk("l1_addr1", 32'(b1.ram_address), 32'h30E51);
    @(negedge clk); chk("l1_addr2", 32'(b1.ram_address), 32'h30E52);
    @(negedge clk); chk("l1_addr3", 32'(b1.ram_address), 32'h30E53);
    @(negedge clk);
    chk("l1_e4_done", 32'(b1.done), 32'h0);
    chk("l1_e4_data", b1.data_out, 32'h0);
    chk("l1_e4_busy", 32'(b1.busy), 32'h1);
    @(negedge clk);
    chk("l1_done", 32'(b1.done), 32'h1);
    chk("l1_data", b1.data_out, 32'h12345678);
    chk("l1_done_busy", 32'(b1.busy), 32'h0);
    chk("l1_done_active", 32'(b1.ram_rd_active), 32'h0);
    @(negedge clk);
    chk("l1_after_done", 32'(b1.done), 32'h0);
    chk("l1_hold_data", b1.data_out, 32'h12345678);
    chk("l1_hold_addr", 32'(b1.ram_address), 32'h30E53);
    // latency 2 read
    @(negedge clk); b2.start = 1'b1; b2.address = 19'h30E50;
    @(negedge clk); b2.start = 1'b0;
    chk("l2_addr0", 32'(b2.ram_address), 32'h30E50);
    repeat (5) @(negedge clk);
    chk("l2_e5_done", 32'(b2.done), 32'h0);
    chk("l2_e5_data", b2.data_out, 32'h0);
    chk("l2_e5_busy", 32'(b2.busy), 32'h1);
    @(negedge clk);
    chk("l2_done", 32'(b2.done), 32'h1);
    chk("l2_data", b2.data_out, 32'h12345678);
    chk("l2_done_busy", 32'(b2.busy), 32'h0);
    @(negedge clk);
    // address wrap
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h7FFFE;
    @(negedge clk); b1.start = 1'b0;
    chk("wr_addr0", 32'(b1.ram_address), 32'h7FFFE);
    @(negedge clk); chk("wr_addr1", 32'(b1.ram_address), 32'h7FFFF);
    @(negedge clk); chk("wr_addr2", 32'(b1.ram_address), 32'h00000);
    @(negedge clk); chk("wr_addr3", 32'(b1.ram_address), 32'h00001);
    repeat (2) @(negedge clk);
    chk("wr_done", 32'(b1.done), 32'h1);
    chk("wr_data", b1.data_out, 32'hDDCCBBAA);
    @(negedge clk);
    // start while busy is ignored
    n_done = 0; n_bad = 0; seen_data = '0;
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h30E50;
    @(negedge clk); b1.start = 1'b0; track();
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h00100; track();
    @(negedge clk); b1.start = 1'b0; track();
    repeat (8) begin @(negedge clk); track(); end
    chk("busy_start_dones", 32'(n_done), 32'd1);
    chk("busy_start_addr100", 32'(n_bad), 32'd0);
    chk("busy_start_data", seen_data, 32'h12345678);
    // reset mid-read
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h7FFFE;
    @(negedge clk); b1.start = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_addr", 32'(b1.ram_address), 32'h0);
    chk("mid_rst_data", b1.data_out, 32'h0);
    chk("mid_rst_busy", 32'(b1.busy), 32'h0);
    chk("mid_rst_active", 32'(b1.ram_rd_active), 32'h0);
    chk("mid_rst_done", 32'(b1.done), 32'h0);
    rst = 1'b1;
    n_done = 0;
    repeat (8) begin @(negedge clk); track(); end
    chk("mid_rst_no_done", 32'(n_done), 32'd0);
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h30E50;
    @(negedge clk); b1.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("post_rst_done", 32'(b1.done), 32'h1);
    chk("post_rst_data", b1.data_out, 32'h12345678);
    @(negedge clk);
    // misaligned base
    @(negedge clk); b1.start = 1'b1; b1.address = 19'h30E51;
    @(negedge clk); b1.start = 1'b0;
`ifdef READ32_ALIGN_CHECK_EN
    chk("mis_done", 32'(b1.done), 32'h1);
    chk("mis_align", 32'(b1.align_err), 32'h1);
    chk("mis_active", 32'(b1.ram_rd_active), 32'h0);
    chk("mis_busy", 32'(b1.busy), 32'h0);
    chk("mis_data", b1.data_out, 32'h12345678);
    chk("mis_addr", 32'(b1.ram_address), 32'h30E53);
    @(negedge clk);
    chk("mis_done_end", 32'(b1.done), 32'h0);
    chk("mis_align_end", 32'(b1.align_err), 32'h0);
`else
    chk("mis_addr0", 32'(b1.ram_address), 32'h30E51);
    chk("mis_align", 32'(b1.align_err), 32'h0);
    chk("mis_busy", 32'(b1.busy), 32'h1);
    repeat (3) @(negedge clk);
    chk("mis_addr3", 32'(b1.ram_address), 32'h30E54);
    repeat (2) @(negedge clk);
    chk("mis_done", 32'(b1.done), 32'h1);
    chk("mis_data", b1.data_out, 32'h9A123456);
    chk("mis_align_done", 32'(b1.align_err), 32'h0);
`endif
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/read_32bit_from_ip_ram.md
Name: read_32bit_from_ip_ram

Overview:
Reads one 32-bit little-endian word from the byte-wide dual-port IP RAM by issuing four consecutive byte addresses and assembling the returned bytes. It is the read-side counterpart of the 32-bit selection writer: it fetches a word such as the selection address data stored at 0x30E50. It sits behind the port-A address mux in mainModule. It drives ram_rd_active so top-level logic can grant it port A.

Parameters:
ADDR_W, 19, RAM byte-address width
READ_LATENCY, 1, cycles from address to valid ram_q; legal range 1..3

Ports:
clk  input  1  system clock; all logic on its rising edge
rst  input  1  synchronous reset, active-low
start  input  1  single-cycle request; sampled only when idle
address  input  ADDR_W  base byte address; sampled with start
ram_q  input  8  RAM port-A read data
ram_address  output  ADDR_W  RAM port-A address, registered
ram_rd_active  output  1  high while this block owns port A
data_out  output  32  assembled word; valid while done=1, then held
done  output  1  one-cycle completion pulse
busy  output  1  transaction in progress
align_err  output  1  one-cycle misalignment flag (optional feature only)

Behaviour:
- Reset, when rst=0 at an edge: state IDLE; ram_address=0, data_out=0, done=0, busy=0, ram_rd_active=0, align_err=0. Reset overrides any in-flight read; no done pulse follows.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: start=1 at edge E0 latches base=address and moves to ISSUE.
- ISSUE: ram_address = base+i during the cycle after edge E(i), for i=0..3. After E3 the state moves to DRAIN.
- DRAIN: waits READ_LATENCY cycles for the last byte, then moves to DONE.
- Read timing: ram_q carries byte i during the cycle after E(i+READ_LATENCY). The block captures byte i at edge E(i+READ_LATENCY+1).
- Byte order: byte i goes to data_out[8i+7:8i]. Byte at base is the LSB, matching the writer.
- data_out is updated in a single step when the last byte is captured at E(READ_LATENCY+4). It never shows partial words.
- DONE: done=1 for exactly the cycle after E(READ_LATENCY+4), then return to IDLE. With READ_LATENCY=1, done follows E5.
- busy and ram_rd_active: high from the cycle after E0 through the last DRAIN cycle. Both are low in the DONE cycle.
- start during ISSUE or DRAIN is ignored and not queued. start during the DONE cycle is also ignored. The earliest re-accept is the first IDLE cycle.
- Address arithmetic is modulo 2^ADDR_W, so base+i wraps past the top address to 0.
- ram_address holds its last value when idle.
- data_out holds its value until the next successful completion.
- The block never writes RAM. Port-A wren and the muxing belong to the top level.

Optional Feature:
Macro READ32_ALIGN_CHECK_EN.
- Defined: start with address[1:0]!=0 is rejected. No RAM addresses are issued and data_out is unchanged. In the next cycle, done=1 and align_err=1 for one cycle, then the block returns to IDLE. busy and ram_rd_active stay 0 throughout. Aligned requests behave as in Behaviour, with align_err=0.
- Undefined: any address is accepted; align_err is tied to 0.

Test Plan:
1. RAM model with latency 1; bytes 0x78,0x56,0x34,0x12 at 0x30E50..0x30E53; start with address=0x30E50 -> ram_address steps 0x30E50..0x30E53 after E0..E3; done pulses after E5 with data_out=0x12345678; busy low in the done cycle.
2. Same data with READ_LATENCY=2 and a latency-2 model -> done after E6, data_out=0x12345678; a data_out check before done shows the old value 0x00000000.
3. ADDR_W=19; bytes 0xAA,0xBB,0xCC,0xDD at 0x7FFFE,0x7FFFF,0x00000,0x00001; start address=0x7FFFE -> ram_address sequence 0x7FFFE,0x7FFFF,0x00000,0x00001; data_out=0xDDCCBBAA.
4. start at E0, second start with address=0x100 at E2 -> exactly one done, data from the first base; ram_address never equals 0x100.
5. Reset: start at E0, rst=0 at E2 -> all outputs 0 from the next cycle; no done; a fresh start afterwards completes normally.
6. With READ32_ALIGN_CHECK_EN defined: start address=0x30E51 -> done=1 and align_err=1 for one cycle after E0; ram_rd_active stays 0; data_out unchanged. Without the macro: the same stimulus reads bytes 0x30E51..0x30E54 and align_err stays 0.
